// File: rtl/ifu_if.sv
// Fetch unit bus bundle: execute-stage npc return, instruction memory request/response
// and decoder output channels.
interface ifu_if;
   logic        npc_valid_i;
   logic [31:0] npc_i;
   logic        npc_ready_o;

   logic        imem_req_valid_o;
   logic        imem_req_ready_i;
   logic [31:0] imem_addr_o;
   logic        imem_rsp_valid_i;
   logic [31:0] imem_rsp_data_i;
   logic        imem_rsp_err_i;

   logic        inst_valid_o;
   logic        inst_ready_i;
   logic [31:0] inst_o;
   logic [31:0] pc_o;
   logic        fetch_err_o;

   modport master (
      input  npc_valid_i, npc_i,
      output npc_ready_o,
      output imem_req_valid_o, imem_addr_o,
      input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, imem_rsp_err_i,
      output inst_valid_o, inst_o, pc_o, fetch_err_o,
      input  inst_ready_i
   );

   modport slave (
      output npc_valid_i, npc_i,
      input  npc_ready_o,
      input  imem_req_valid_o, imem_addr_o,
      output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, imem_rsp_err_i,
      input  inst_valid_o, inst_o, pc_o, fetch_err_o,
      output inst_ready_i
   );
endinterface

// File: rtl/ifu.sv
// Non-pipelined instruction fetch unit: one instruction in flight from fetch request
// until the execute stage returns its next PC.
module ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter logic [15:0] TIMEOUT  = 16'd1023
) (
   input  logic  clk_i,
   input  logic  rst_i,
   ifu_if.master bus
);
   localparam int unsigned XLEN = 32;
   localparam int unsigned TW   = 16;

   typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, NPC} state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] inst_q, inst_d;
   logic            err_q, err_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            req_valid_q, inst_valid_q, npc_ready_q;
   logic            tmo_hit;

   // Zero TIMEOUT disables the watchdog entirely.
   assign tmo_hit = (TIMEOUT != TW'(0)) && (tmo_q == TIMEOUT - TW'(1));

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      err_d   = err_q;
      tmo_d   = tmo_q;
      unique case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            // A misaligned PC is reported as a faulting instruction without touching memory.
            if (pc_q[1:0] != 2'b00) begin
               inst_d  = '0;
               err_d   = 1'b1;
               state_d = OUT;
            end else if (bus.imem_req_ready_i) begin
               tmo_d   = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            // A response landing on the timeout cycle takes priority over the timeout.
            if (bus.imem_rsp_valid_i) begin
               inst_d  = bus.imem_rsp_data_i;
               err_d   = bus.imem_rsp_err_i;
               state_d = OUT;
            end else begin
               tmo_d = tmo_q + TW'(1);
               if (tmo_hit) begin
                  inst_d  = '0;
                  err_d   = 1'b1;
                  state_d = OUT;
               end
            end
         end
         OUT: begin
            if (bus.inst_ready_i) state_d = NPC;
         end
         NPC: begin
            if (bus.npc_valid_i) begin
               pc_d    = bus.npc_i;
               err_d   = 1'b0;
               state_d = REQ;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs are registered from the next state so they track the state exactly.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         inst_q       <= '0;
         err_q        <= 1'b0;
         tmo_q        <= '0;
         req_valid_q  <= 1'b0;
         inst_valid_q <= 1'b0;
         npc_ready_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         err_q        <= err_d;
         tmo_q        <= tmo_d;
         req_valid_q  <= (state_d == REQ) && (pc_d[1:0] == 2'b00);
         inst_valid_q <= (state_d == OUT);
         npc_ready_q  <= (state_d == NPC);
      end
   end

   assign bus.imem_req_valid_o = req_valid_q;
   assign bus.imem_addr_o      = pc_q;
   assign bus.inst_valid_o     = inst_valid_q;
   assign bus.inst_o           = inst_q;
   assign bus.pc_o             = pc_q;
   assign bus.fetch_err_o      = err_q;
   assign bus.npc_ready_o      = npc_ready_q;
endmodule

// File: tb/tb_ifu.sv
// Randomized bench for ifu: transaction-level model of memory, decoder and execute
// stage, driven and sampled on the falling clock edge.
module tb_ifu;
   localparam logic [31:0] RST_PC = 32'h8000_0000;
   localparam int          TMO    = 4;
   localparam int          N_INST = 400;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ifu_if bus ();

   ifu #(.RESET_PC(RST_PC), .TIMEOUT(16'(TMO))) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
   endtask

   // Model state
   logic [31:0] exp_pc, exp_inst, pend_data;
   logic        exp_err, pend_err;
   int          n_inst, req_this, rsp_cnt, acc_cyc, exp_out_cyc;
   int          rdy_wait, dec_wait, npc_wait;
   bit          req_seen, out_seen, npc_seen;
   int          cyc, since_rst, rst_hold, next_rst_at, last_req_cyc, last_fire_cyc;
   bit          rst_prev, drive_rst, prev_reqv, abort;
   bit          prev_req_stall, prev_out_stall;
   logic [31:0] prev_addr, prev_inst, prev_pcv;
   logic        prev_err;

   initial begin
      logic        req_v, inst_v, npc_r, f_err;
      logic [31:0] addr, inst, pcv;
      logic        req_r, dec_r, nv, rsp_v, rsp_e;
      logic [31:0] nval, rsp_d;
      int          d;

      rst = 1'b1;
      bus.npc_valid_i = 0; bus.npc_i = '0; bus.imem_req_ready_i = 0;
      bus.imem_rsp_valid_i = 0; bus.imem_rsp_data_i = '0; bus.imem_rsp_err_i = 0;
      bus.inst_ready_i = 0;
      exp_pc = RST_PC; exp_inst = '0; exp_err = 0; pend_data = '0; pend_err = 0;
      n_inst = 0; req_this = 0; rsp_cnt = 0; acc_cyc = 0; exp_out_cyc = 0;
      rdy_wait = 0; dec_wait = 0; npc_wait = 0;
      req_seen = 0; out_seen = 0; npc_seen = 0;
      cyc = 0; since_rst = 0; rst_hold = 3; next_rst_at = 20;
      last_req_cyc = 0; last_fire_cyc = 0; prev_reqv = 0; abort = 0;
      prev_req_stall = 0; prev_out_stall = 0;
      prev_addr = '0; prev_inst = '0; prev_pcv = '0; prev_err = 0;

      while (n_inst < N_INST && !abort) begin
         @(negedge clk);
         cyc++;
         rst_prev  = rst;
         since_rst = rst_prev ? 1 : since_rst + 1;
         req_v = bus.imem_req_valid_o; addr  = bus.imem_addr_o;
         inst_v = bus.inst_valid_o;    inst  = bus.inst_o;
         pcv   = bus.pc_o;             f_err = bus.fetch_err_o;
         npc_r = bus.npc_ready_o;

         // Reset state and first request after release
         if (rst_prev) begin
            check("rst_req_valid", 32'(req_v), 32'd0);
            check("rst_inst_valid", 32'(inst_v), 32'd0);
            check("rst_npc_ready", 32'(npc_r), 32'd0);
            check("rst_pc", pcv, RST_PC);
         end else if (since_rst == 2) begin
            check("boot_req_valid", 32'(req_v), 32'd1);
            check("boot_addr", addr, RST_PC);
         end
         check("pc_eq_addr", pcv, addr);

         if (prev_req_stall) begin
            check("req_held", 32'(req_v), 32'd1);
            check("addr_stable", addr, prev_addr);
         end
         if (prev_out_stall) begin
            check("out_held", 32'(inst_v), 32'd1);
            check("inst_stable", inst, prev_inst);
            check("pc_stable", pcv, prev_pcv);
            check("err_stable", 32'(f_err), 32'(prev_err));
         end

         // Ideal-timing instructions: one request every 4 cycles (REQ, WAIT, OUT, NPC)
         if (req_v && !prev_reqv) begin
            if (n_inst >= 1 && n_inst <= 2)
               check("spacing", 32'(cyc - last_req_cyc), 32'd4);
            last_req_cyc = cyc;
         end
         prev_reqv = req_v;

         if (cyc - last_fire_cyc > 200) begin
            check("progress_timeout", 32'(cyc - last_fire_cyc), 32'd0);
            abort = 1;
         end

         drive_rst = 0;
         if (rst_hold > 0) begin
            rst_hold--;
            drive_rst = 1;
         end else if (n_inst >= next_rst_at && rsp_cnt >= 2 && (cyc - acc_cyc) <= TMO) begin
            drive_rst   = 1;
            next_rst_at = next_rst_at + 60;
         end

         req_r = 0; dec_r = 0; nv = 0; nval = $urandom;
         rsp_v = 0; rsp_d = $urandom; rsp_e = 1'($urandom % 2);

         if (drive_rst) begin
            // Reset in WAIT: the pending response is delivered into IDLE or REQ and must be dropped
            if (rsp_cnt > 0) begin
               rsp_cnt   = 1 + int'($urandom % 2);
               pend_data = $urandom;
               pend_err  = 1'($urandom % 2);
            end
            exp_pc = RST_PC; req_this = 0;
            req_seen = 0; out_seen = 0; npc_seen = 0;
            last_fire_cyc = cyc;
         end else begin
            // Memory response side
            if (rsp_cnt > 0) begin
               rsp_cnt--;
               if (rsp_cnt == 0) begin
                  rsp_v = 1; rsp_d = pend_data; rsp_e = pend_err;
               end
            end else if ($urandom % 4 == 0) begin
               rsp_v = 1;
            end

            // Memory request side
            req_r = 1'($urandom % 2);
            if (req_v) begin
               if (!req_seen) begin
                  req_seen = 1;
                  rdy_wait = (n_inst < 3) ? 0 : (n_inst == 3) ? 3 : int'($urandom % 4);
               end
               if (rsp_cnt > 0) req_r = 0;
               else if (rdy_wait > 0) begin
                  req_r = 0;
                  rdy_wait--;
               end else begin
                  req_r = 1;
                  check("req_addr", addr, exp_pc);
                  req_this++;
                  req_seen = 0;
                  acc_cyc  = cyc;
                  if (n_inst < 3) begin
                     d = 1; pend_data = 32'h0000_0013; pend_err = 0;
                  end else if (n_inst == 5) begin
                     d = 1 + int'($urandom % 2); pend_data = $urandom; pend_err = 1;
                  end else if (n_inst == 6) begin
                     d = TMO + 1; pend_data = $urandom; pend_err = 0;
                  end else begin
                     d = 1 + int'($urandom % 6); pend_data = $urandom;
                     pend_err = ($urandom % 8 == 0);
                  end
                  rsp_cnt = d;
                  if (d > TMO) begin
                     exp_inst = '0; exp_err = 1; exp_out_cyc = cyc + TMO + 1;
                  end else begin
                     exp_inst = pend_data; exp_err = pend_err; exp_out_cyc = cyc + d + 1;
                  end
               end
            end

            // Decoder
            dec_r = 1'($urandom % 2);
            if (inst_v) begin
               if (!out_seen) begin
                  out_seen = 1;
                  dec_wait = (n_inst < 3) ? 0 : (n_inst == 3) ? 2 : int'($urandom % 3);
                  if (exp_pc[1:0] == 2'b00) check("out_latency", 32'(cyc), 32'(exp_out_cyc));
               end
               if (dec_wait > 0) begin
                  dec_r = 0;
                  dec_wait--;
               end else begin
                  dec_r = 1;
                  check("pc_o", pcv, exp_pc);
                  if (exp_pc[1:0] != 2'b00) begin
                     check("misalign_inst", inst, 32'd0);
                     check("misalign_err", 32'(f_err), 32'd1);
                     check("misalign_no_req", 32'(req_this), 32'd0);
                  end else begin
                     check("inst_o", inst, exp_inst);
                     check("fetch_err", 32'(f_err), 32'(exp_err));
                     check("one_req", 32'(req_this), 32'd1);
                  end
                  n_inst++;
                  out_seen = 0;
                  last_fire_cyc = cyc;
               end
            end

            // Execute stage
            nv = ($urandom % 4 == 0);
            if (npc_r) begin
               if (!npc_seen) begin
                  npc_seen = 1;
                  npc_wait = (n_inst <= 4) ? 0 : int'($urandom % 3);
               end
               if (npc_wait > 0) begin
                  nv = 0;
                  npc_wait--;
               end else begin
                  nv = 1;
                  if (n_inst <= 3) nval = exp_pc + 32'd4;
                  else if (n_inst == 4) nval = 32'h8000_0102;
                  else if (n_inst == 5) nval = 32'h8000_0200;
                  else begin
                     case ($urandom % 8)
                        0:       nval = {nval[31:2], 2'(1 + $urandom % 3)};
                        1:       nval = {nval[31:2], 2'b00};
                        default: nval = exp_pc + 32'd4;
                     endcase
                  end
                  exp_pc   = nval;
                  req_this = 0;
                  npc_seen = 0;
               end
            end
         end

         prev_req_stall = !drive_rst && req_v && !req_r;
         prev_out_stall = !drive_rst && inst_v && !dec_r;
         prev_addr = addr; prev_inst = inst; prev_pcv = pcv; prev_err = f_err;

         rst = drive_rst;
         bus.imem_req_ready_i = req_r;
         bus.imem_rsp_valid_i = rsp_v;
         bus.imem_rsp_data_i  = rsp_d;
         bus.imem_rsp_err_i   = rsp_e;
         bus.inst_ready_i     = dec_r;
         bus.npc_valid_i      = nv;
         bus.npc_i            = nval;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
